// File: rtl/gpio_link_rx.sv
// -----------------------------------------------------------------------------
// gpio_link_rx
//
// Receive end of the inter-board GPIO mouse-button link. The peer board drives
// two raw button lines (left, right) that are asynchronous to clk. Each line is
// synchronized, glitch-filtered and presented as a clean level plus one-cycle
// press/release pulses. A registered AND of both clean levels is also provided.
//
// Parameters:
//   SYNC_STAGES   - depth of each input synchronizer chain (>= 2)
//   FILTER_CYCLES - consecutive synchronized cycles a new value must hold
//                   before the clean level follows it (>= 1)
//   CNT_W         - stability counter width, 2**CNT_W >= FILTER_CYCLES
//
// Ports:
//   clk           - system clock (clk_40 domain)
//   rst           - asynchronous, active-high reset
//   gpio_left     - raw left-button line, asynchronous to clk
//   gpio_right    - raw right-button line, asynchronous to clk
//   m_left        - filtered left-button level
//   m_right       - filtered right-button level
//   left_press    - one-cycle pulse when m_left rises
//   left_release  - one-cycle pulse when m_left falls
//   right_press   - one-cycle pulse when m_right rises
//   right_release - one-cycle pulse when m_right falls
//   both_active   - m_left & m_right, registered (one cycle behind the levels)
//
// Latency: a pin change reaches the clean level on the
// (SYNC_STAGES + FILTER_CYCLES)-th rising edge after the change, counting the
// first edge that samples the new pin value as edge 1.
// -----------------------------------------------------------------------------
module gpio_link_rx #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4000,
    parameter int unsigned CNT_W         = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic gpio_left,
    input  logic gpio_right,
    output logic m_left,
    output logic m_right,
    output logic left_press,
    output logic left_release,
    output logic right_press,
    output logic right_release,
    output logic both_active
);

    // Line 0 is left, line 1 is right; both lines use identical logic.
    localparam int NumLines = 2;

    // Terminal count: the filter accepts a change on the cycle that would take
    // the counter past this value, so the counter never exceeds it.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(FILTER_CYCLES - 1);

    typedef enum logic {
        StLow  = 1'b0,
        StHigh = 1'b1
    } line_state_e;

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic [NumLines-1:0]    pin_raw;
    logic [SYNC_STAGES-1:0] sync_q [NumLines];
    logic [SYNC_STAGES-1:0] sync_d [NumLines];
    logic [NumLines-1:0]    sync_s;

    assign pin_raw = {gpio_right, gpio_left};

    // Shift the raw pin into bit 0; the synchronized value is the top stage.
    // The raw pin reaches nothing else in the design.
    always_comb begin
        sync_s = '0;
        for (int i = 0; i < NumLines; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pin_raw[i]};
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumLines; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumLines; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-line glitch filter FSM with registered outputs
    // -------------------------------------------------------------------------
    // In each state the counter tracks how many consecutive cycles the
    // synchronized value has disagreed with the current clean level. Any
    // agreeing cycle restarts the count, so only a run of FILTER_CYCLES
    // disagreeing cycles flips the level. Press and release are driven from
    // mutually exclusive branches, so they can never coincide on one line.
    line_state_e         state_q [NumLines];
    logic [CNT_W-1:0]    cnt_q   [NumLines];
    logic [NumLines-1:0] level_q;
    logic [NumLines-1:0] press_q;
    logic [NumLines-1:0] release_q;
    logic                both_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumLines; i++) begin
                state_q[i] <= StLow;
                cnt_q[i]   <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            both_q    <= 1'b0;
        end else begin
            // Sampled from the registered levels, hence one cycle behind them.
            both_q <= level_q[0] & level_q[1];

            for (int i = 0; i < NumLines; i++) begin
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;

                unique case (state_q[i])
                    StLow: begin
                        if (sync_s[i]) begin
                            if (cnt_q[i] == CntLast) begin
                                state_q[i] <= StHigh;
                                level_q[i] <= 1'b1;
                                press_q[i] <= 1'b1;
                                cnt_q[i]   <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
                        end else begin
                            cnt_q[i] <= '0;
                        end
                    end

                    StHigh: begin
                        if (!sync_s[i]) begin
                            if (cnt_q[i] == CntLast) begin
                                state_q[i]   <= StLow;
                                level_q[i]   <= 1'b0;
                                release_q[i] <= 1'b1;
                                cnt_q[i]     <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
                        end else begin
                            cnt_q[i] <= '0;
                        end
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign m_left        = level_q[0];
    assign m_right       = level_q[1];
    assign left_press    = press_q[0];
    assign left_release  = release_q[0];
    assign right_press   = press_q[1];
    assign right_release = release_q[1];
    assign both_active   = both_q;

endmodule
